// File: rtl/ex_alu_stage.sv
// ex_alu_stage: RV32I execute stage, ALU result registered into EX/MEM with valid/ready handshake.
// Optional EX_ALU_SKID_EN adds a one-entry skid buffer and a registered o_ready.
module ex_alu_sra #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [4:0]      shamt,
  output logic [XLEN-1:0] y
);
  assign y = $signed(a) >>> shamt;
endmodule

module ex_alu_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [3:0]      i_op,
  input  logic [RD_W-1:0] i_rd,
  input  logic            i_we,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [RD_W-1:0] o_rd,
  output logic            o_we
);
  logic [4:0]      shamt;
  logic [XLEN-1:0] sra_y;
  logic [XLEN-1:0] alu_r;
  logic            op_ok;
  logic            we_c;
  logic            accept;
  assign shamt = i_b[4:0];
  ex_alu_sra #(.XLEN(XLEN)) u_sra (.a(i_a), .shamt(shamt), .y(sra_y));
  always_comb begin
    alu_r = '0;
    op_ok = 1'b1;
    case (i_op)
      4'b0000: alu_r = i_a + i_b;
      4'b1000: alu_r = i_a - i_b;
      4'b0001: alu_r = i_a << shamt;
      4'b0010: alu_r = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      4'b0011: alu_r = {{(XLEN-1){1'b0}}, i_a < i_b};
      4'b0100: alu_r = i_a ^ i_b;
      4'b0101: alu_r = i_a >> shamt;
      4'b1101: alu_r = sra_y;
      4'b0110: alu_r = i_a | i_b;
      4'b0111: alu_r = i_a & i_b;
      default: op_ok = 1'b0;
    endcase
  end
  assign we_c   = i_we && op_ok && (i_rd != '0);
  assign accept = i_valid && o_ready && !i_flush;
`ifdef EX_ALU_SKID_EN
  logic            skid_valid;
  logic [XLEN-1:0] skid_result;
  logic [RD_W-1:0] skid_rd;
  logic            skid_we;
  assign o_ready = !skid_valid;
  // The skid entry always drains before a new op can land, so ordering is kept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid     <= 1'b0;
      o_result    <= '0;
      o_rd        <= '0;
      o_we        <= 1'b0;
      skid_valid  <= 1'b0;
      skid_result <= '0;
      skid_rd     <= '0;
      skid_we     <= 1'b0;
    end else if (i_flush) begin
      o_valid    <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!o_valid || i_ready) begin
      if (skid_valid) begin
        o_valid    <= 1'b1;
        o_result   <= skid_result;
        o_rd       <= skid_rd;
        o_we       <= skid_we;
        skid_valid <= 1'b0;
      end else if (accept) begin
        o_valid  <= 1'b1;
        o_result <= alu_r;
        o_rd     <= i_rd;
        o_we     <= we_c;
      end else begin
        o_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid  <= 1'b1;
      skid_result <= alu_r;
      skid_rd     <= i_rd;
      skid_we     <= we_c;
    end
  end
`else
  assign o_ready = !o_valid || i_ready;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_rd     <= '0;
      o_we     <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      o_valid  <= 1'b1;
      o_result <= alu_r;
      o_rd     <= i_rd;
      o_we     <= we_c;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: scoreboard bench for ex_alu_stage; directed ALU cases, backpressure, flush, random traffic.
module tb_ex_alu_stage;
`ifdef EX_ALU_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  typedef struct packed {
    logic [31:0] r;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic [3:0]  i_op = '0;
  logic [4:0]  i_rd = '0;
  logic        i_we = 1'b0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_result;
  logic [4:0]  o_rd;
  logic        o_we;

  int   total = 0;
  int   bad = 0;
  int   n_out = 0;
  int   n_in = 0;
  exp_t q[$];
  logic held = 1'b0;
  exp_t h;
  exp_t e;
  logic rnd_done;

  ex_alu_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_op(i_op), .i_rd(i_rd), .i_we(i_we),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_rd(o_rd), .o_we(o_we)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] s;
    s = b[4:0];
    case (op)
      4'b0000: return {1'b1, a + b};
      4'b1000: return {1'b1, a - b};
      4'b0001: return {1'b1, a << s};
      4'b0010: return {1'b1, 31'd0, (a[31] != b[31]) ? a[31] : (a < b)};
      4'b0011: return {1'b1, 31'd0, a < b};
      4'b0100: return {1'b1, a ^ b};
      4'b0101: return {1'b1, a >> s};
      4'b1101: return {1'b1, a[31] ? ~(~a >> s) : (a >> s)};
      4'b0110: return {1'b1, a | b};
      4'b0111: return {1'b1, a & b};
      default: return 33'd0;
    endcase
  endfunction

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic we, input logic [31:0] er, input logic ewe);
    exp_t x;
    i_op = op; i_a = a; i_b = b; i_rd = rd; i_we = we; i_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge i_clk);
      #1;
      if (o_ready) begin
        x.r = er; x.rd = rd; x.we = ewe;
        q.push_back(x);
        n_in++;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        return;
      end
      @(posedge i_clk);
      #1;
    end
    check("send_timeout", 32'd0, 32'd1);
    i_valid = 1'b0;
  endtask

  task automatic settle();
    i_ready = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
  endtask

  always @(negedge i_clk) begin
    if (i_rst) begin
      q.delete();
      held = 1'b0;
    end else begin
      if (held && o_valid) begin
        check("hold_result", o_result, h.r);
        check("hold_rd", {27'd0, o_rd}, {27'd0, h.rd});
        check("hold_we", {31'd0, o_we}, {31'd0, h.we});
      end
      held = o_valid && !i_ready && !i_flush;
      h.r = o_result; h.rd = o_rd; h.we = o_we;
      if (o_valid && i_ready) begin
        if (q.size() == 0) check("extra_out", 32'(q.size()), 32'd1);
        else begin
          e = q.pop_front();
          n_out++;
          check("result", o_result, e.r);
          check("rd", {27'd0, o_rd}, {27'd0, e.rd});
          check("we", {31'd0, o_we}, {31'd0, e.we});
        end
      end
      if (i_flush) q.delete();
    end
  end

  initial begin
    logic [32:0] m;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;
    logic        rwe;
    repeat (3) @(negedge i_clk);
    check("reset_o_valid", {31'd0, o_valid}, 32'd0);
    check("reset_o_we", {31'd0, o_we}, 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("ready_after_reset", {31'd0, o_ready}, 32'd1);
    send(4'b0000, 32'h7FFF_FFFF, 32'd1, 5'd3, 1'b1, 32'h8000_0000, 1'b1);
    check("first_latency_valid", {31'd0, o_valid}, 32'd1);
    send(4'b1000, 32'd5, 32'd7, 5'd4, 1'b1, 32'hFFFF_FFFE, 1'b1);
    send(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1, 32'd1, 1'b1);
    send(4'b0011, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b1, 32'd0, 1'b1);
    send(4'b1101, 32'h8000_0000, 32'h24, 5'd7, 1'b1, 32'hF800_0000, 1'b1);
    send(4'b0101, 32'h8000_0000, 32'h24, 5'd8, 1'b1, 32'h0800_0000, 1'b1);
    send(4'b0001, 32'd1, 32'd31, 5'd9, 1'b1, 32'h8000_0000, 1'b1);
    send(4'b0100, 32'hF0F0, 32'h00FF, 5'd10, 1'b1, 32'hF00F, 1'b1);
    send(4'b0110, 32'hF0F0, 32'h00FF, 5'd11, 1'b0, 32'hF0FF, 1'b0);
    send(4'b0111, 32'hF0F0, 32'h00FF, 5'd12, 1'b1, 32'h00F0, 1'b1);
    send(4'b0000, 32'hFFFF_FFFF, 32'd2, 5'd13, 1'b1, 32'd1, 1'b1);
    send(4'b0000, 32'd2, 32'd3, 5'd0, 1'b1, 32'd5, 1'b0);
    send(4'b1001, 32'd5, 32'd3, 5'd14, 1'b1, 32'd0, 1'b0);
    settle();
    i_ready = 1'b0;
    fork
      begin
        send(4'b0000, 32'd100, 32'd1, 5'd1, 1'b1, 32'd101, 1'b1);
        send(4'b0000, 32'd200, 32'd2, 5'd2, 1'b1, 32'd202, 1'b1);
        send(4'b0000, 32'd300, 32'd3, 5'd3, 1'b1, 32'd303, 1'b1);
      end
      begin
        @(posedge i_clk);
        @(negedge i_clk);
        check("bp_ready_cycle1", {31'd0, o_ready}, {31'd0, SKID});
        @(posedge i_clk);
        @(negedge i_clk);
        check("bp_ready_cycle2", {31'd0, o_ready}, 32'd0);
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
      end
    join
    settle();
    check("bp_drained", 32'(q.size()), 32'd0);
    i_ready = 1'b0;
    send(4'b0000, 32'd40, 32'd2, 5'd9, 1'b1, 32'd42, 1'b1);
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_op = 4'b0000; i_a = 32'h1000; i_b = 32'h234; i_rd = 5'd17; i_we = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("flush_o_valid", {31'd0, o_valid}, 32'd0);
    check("flush_o_ready", {31'd0, o_ready}, 32'd1);
    settle();
    check("flush_no_output", {31'd0, o_valid}, 32'd0);
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          rop = 4'($urandom); ra = $urandom; rb = $urandom; rrd = 5'($urandom); rwe = 1'($urandom);
          if (k % 5 == 0) rb = {27'd0, 5'($urandom)};
          m = ref_alu(rop, ra, rb);
          send(rop, ra, rb, rrd, rwe, m[31:0], m[32] && rwe && (rrd != 5'd0));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge i_clk);
          #1;
          i_ready = 1'($urandom);
        end
      end
    join
    settle();
    check("final_drain", 32'(q.size()), 32'd0);
    check("in_out_count", 32'(n_out), 32'(n_in - 1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
